// File: rtl/uart_rx_oversampled_if.sv
// Receiver-to-FIFO interface: write strobe, received byte and line-status flags.
// rx_valid is a one-cycle strobe with no ready: the consumer must take every strobe.
interface uart_rx_oversampled_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       framing_error;
    logic       break_detect;
    logic       parity_error;

    modport master (output rx_valid, rx_data, framing_error, break_detect, parity_error);
    modport slave  (input  rx_valid, rx_data, framing_error, break_detect, parity_error);
endinterface

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver: majority-vote bit sampling, false-start, framing and break detection.
// Defining UART_RX_PARITY_EN inserts a parity bit between the data bits and the stop bit.
module uart_rx_oversampled #(
    parameter int CLOCK_FREQUENCY = 100000000,
    parameter int BAUD_RATE       = 115200,
    parameter int OVERSAMPLE      = 16,
    parameter int PARITY_ODD      = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  serial_rx,
    uart_rx_oversampled_if.master rx,
    output logic [2:0]            debug_state
);
    localparam int DIVISOR = CLOCK_FREQUENCY / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int SCNT_W  = $clog2(OVERSAMPLE);
    localparam int MID     = OVERSAMPLE / 2;

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIVISOR - 1);
    localparam logic [SCNT_W-1:0] SC_PRE   = SCNT_W'(MID - 1);
    localparam logic [SCNT_W-1:0] SC_MID   = SCNT_W'(MID);
    localparam logic [SCNT_W-1:0] SC_DEC   = SCNT_W'(MID + 1);
    localparam logic [SCNT_W-1:0] SC_LAST  = SCNT_W'(OVERSAMPLE - 1);

    generate
        if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 8 || DIVISOR < 1 ||
            (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_params
            $error("uart_rx_oversampled: unsupported parameter set");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                rxs_meta, rxs;
    logic [DIV_W-1:0]    div_cnt;
    logic [SCNT_W-1:0]   scnt;
    logic                hold_cnt, tick, at_dec, at_last;
    logic                vote_a, vote_b, vote;
    logic [2:0]          bit_idx;
    logic [7:0]          shift_q;
    logic                stop_bad;
    logic                do_valid, do_ferr, do_perr;
    logic                rx_valid_q, ferr_q, perr_q;
    logic [7:0]          rx_data_q;
`ifdef UART_RX_PARITY_EN
    logic                par_q;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rxs_meta <= 1'b1;
            rxs      <= 1'b1;
        end else begin
            rxs_meta <= serial_rx;
            rxs      <= rxs_meta;
        end
    end

    // Holding the divider in IDLE aligns the sample phase to the start edge; in BREAK
    // it restarts the one-bit high-time measurement whenever the line drops again.
    assign hold_cnt = (state_q == S_IDLE) || (state_q == S_BREAK && !rxs);
    assign tick     = !hold_cnt && (div_cnt == DIV_LAST);
    assign at_dec   = tick && (scnt == SC_DEC);
    assign at_last  = tick && (scnt == SC_LAST);
    assign vote     = (vote_a & vote_b) | (vote_a & rxs) | (vote_b & rxs);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            scnt    <= '0;
        end else begin
            if (hold_cnt || div_cnt == DIV_LAST) div_cnt <= '0;
            else                                 div_cnt <= div_cnt + 1'b1;
            if (hold_cnt)  scnt <= '0;
            else if (tick) scnt <= (scnt == SC_LAST) ? '0 : scnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vote_a   <= 1'b1;
            vote_b   <= 1'b1;
            bit_idx  <= 3'd0;
            shift_q  <= 8'h00;
            stop_bad <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            if (tick && scnt == SC_PRE) vote_a <= rxs;
            if (tick && scnt == SC_MID) vote_b <= rxs;
            if (state_q != S_DATA) bit_idx <= 3'd0;
            else if (at_last)      bit_idx <= bit_idx + 3'd1;
            if (state_q == S_DATA && at_dec) shift_q <= {vote, shift_q[7:1]};
`ifdef UART_RX_PARITY_EN
            if (state_q == S_PARITY && at_dec) par_q <= vote;
`endif
            if (state_q != S_STOP)                  stop_bad <= 1'b0;
            else if (!stop_bad && at_dec && !vote)  stop_bad <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!rxs) state_d = S_START;
            S_START: begin
                if (at_dec && vote) state_d = S_IDLE;
                else if (at_last)   state_d = S_DATA;
            end
            S_DATA: begin
`ifdef UART_RX_PARITY_EN
                if (at_last && bit_idx == 3'd7) state_d = S_PARITY;
`else
                if (at_last && bit_idx == 3'd7) state_d = S_STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (at_last) state_d = S_STOP;
`endif
            S_STOP: begin
                // A failed non-zero frame lingers here until the line idles high again.
                if (stop_bad) begin
                    if (rxs) state_d = S_IDLE;
                end else if (at_dec) begin
                    if (vote)                  state_d = S_IDLE;
                    else if (shift_q == 8'h00) state_d = S_BREAK;
                end
            end
            S_BREAK: if (at_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        do_valid = 1'b0;
        do_ferr  = 1'b0;
        do_perr  = 1'b0;
        if (state_q == S_STOP && !stop_bad && at_dec) begin
            if (!vote) do_ferr = 1'b1;
`ifdef UART_RX_PARITY_EN
            else if (par_q != ((^shift_q) ^ 1'(PARITY_ODD))) do_perr = 1'b1;
`endif
            else do_valid = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_valid_q <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            rx_data_q  <= 8'h00;
        end else begin
            rx_valid_q <= do_valid;
            ferr_q     <= do_ferr;
            perr_q     <= do_perr;
            if (do_valid) rx_data_q <= shift_q;
        end
    end

    assign rx.rx_valid      = rx_valid_q;
    assign rx.rx_data       = rx_data_q;
    assign rx.framing_error = ferr_q;
    assign rx.parity_error  = perr_q;
    assign rx.break_detect  = (state_q == S_BREAK);
    assign debug_state      = state_q;
endmodule
